// File: rtl/adaptive_phase_ctrl_pkg.sv
// Shared constants for the adaptive traffic-phase controller:
// FSM state encodings and bit positions inside each phase's light triplet.
package adaptive_phase_ctrl_pkg;

    localparam logic [1:0] ST_CLEAR  = 2'd0;
    localparam logic [1:0] ST_GREEN  = 2'd1;
    localparam logic [1:0] ST_YELLOW = 2'd2;

    localparam int GREEN_B = 2;
    localparam int YEL_B   = 1;
    localparam int RED_B   = 0;

endpackage

// File: rtl/adaptive_phase_ctrl_phase_select.sv
// Rotate-priority search for the next phase to serve, starting one past the
// current phase and wrapping round to the current phase itself.
module adaptive_phase_ctrl_phase_select
    import adaptive_phase_ctrl_pkg::*;
#(
    parameter int N_PHASES   = 3,
    parameter int CNT_W      = 4,
    parameter int SKIP_EMPTY = 1
) (
    input  logic [N_PHASES*CNT_W-1:0]   count_i,
    input  logic [$clog2(N_PHASES)-1:0] phase_i,
    output logic [$clog2(N_PHASES)-1:0] next_phase_o,
    output logic [CNT_W-1:0]            sel_count_o
);

    localparam int PW = $clog2(N_PHASES);

    logic found;
    int   cand;

    always_comb begin
        // NOTE: every signal written here gets a value before any branch,
        // so no path can leave it unassigned and infer a latch.
        found        = 1'b0;
        cand         = 0;
        next_phase_o = (phase_i == PW'(N_PHASES - 1)) ? '0 : phase_i + 1'b1;
        for (int k = 1; k <= N_PHASES; k++) begin
            cand = int'(phase_i) + k;
            if (cand >= N_PHASES) begin
                cand = cand - N_PHASES;
            end
            if (SKIP_EMPTY != 0 && !found && count_i[cand*CNT_W +: CNT_W] != '0) begin
                found        = 1'b1;
                next_phase_o = PW'(cand);
            end
        end
        sel_count_o = count_i[next_phase_o*CNT_W +: CNT_W];
    end

endmodule

// File: rtl/adaptive_phase_ctrl.sv
// Count-adaptive round-robin traffic-phase controller with hold and
// emergency pre-emption; all outputs are registered.
module adaptive_phase_ctrl
    import adaptive_phase_ctrl_pkg::*;
#(
    parameter int N_PHASES    = 3,
    parameter int CNT_W       = 4,
    parameter int TW          = 6,
    parameter int G_MIN       = 10,
    parameter int G_MAX       = 30,
    parameter int EXT_PER_CAR = 2,
    parameter int Y_TICKS     = 4,
    parameter int R_TICKS     = 2,
    parameter int SKIP_EMPTY  = 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        tick_i,
    input  logic [N_PHASES*CNT_W-1:0]   count_i,
    input  logic                        emergency_i,
    input  logic                        hold_i,
    output logic [3*N_PHASES-1:0]       lights_o,
    output logic [$clog2(N_PHASES)-1:0] phase_o,
    output logic [1:0]                  state_o,
    output logic [TW-1:0]               remaining_o,
    output logic [TW-1:0]               g_len_o,
    output logic                        phase_start_o
);

    localparam int            PW      = $clog2(N_PHASES);
    localparam logic [TW-1:0] Y_LOAD  = TW'(Y_TICKS - 1);
    localparam logic [TW-1:0] R_LOAD  = TW'(R_TICKS - 1);
    localparam logic [31:0]   EXT_CAP = 32'(G_MAX - G_MIN);

    logic [1:0]           state_q, state_d;
    logic [PW-1:0]        phase_q, phase_d;
    logic [TW-1:0]        remaining_q, remaining_d;
    logic [TW-1:0]        g_len_q, g_len_d;
    logic                 phase_start_q, phase_start_d;
    logic [3*N_PHASES-1:0] lights_q, lights_d;

    logic [PW-1:0]    next_phase;
    logic [CNT_W-1:0] sel_count;
    logic [31:0]      ext_full, ext_sat;
    logic [TW-1:0]    green_len;
    logic             step, expired;

    adaptive_phase_ctrl_phase_select #(
        .N_PHASES   (N_PHASES),
        .CNT_W      (CNT_W),
        .SKIP_EMPTY (SKIP_EMPTY)
    ) u_phase_select (
        .count_i      (count_i),
        .phase_i      (phase_q),
        .next_phase_o (next_phase),
        .sel_count_o  (sel_count)
    );

    // Extension is saturated in 32 bits so a large count cannot wrap.
    assign ext_full  = 32'(sel_count) * 32'(EXT_PER_CAR);
    assign ext_sat   = (ext_full > EXT_CAP) ? EXT_CAP : ext_full;
    assign green_len = TW'(32'(G_MIN) + ext_sat);

    assign step    = tick_i & ~hold_i;
    assign expired = (remaining_q == '0);

    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        remaining_d   = remaining_q;
        g_len_d       = g_len_q;
        phase_start_d = 1'b0;
        case (state_q)
            ST_GREEN: begin
                if (emergency_i || (step && expired)) begin
                    state_d     = ST_YELLOW;
                    remaining_d = Y_LOAD;
                end else if (step) begin
                    remaining_d = remaining_q - 1'b1;
                end
            end
            ST_YELLOW: begin
                if (step && expired) begin
                    state_d     = ST_CLEAR;
                    remaining_d = R_LOAD;
                end else if (step) begin
                    remaining_d = remaining_q - 1'b1;
                end
            end
            ST_CLEAR: begin
                // An expired clearance parks at zero while pre-empted.
                if (step && expired && !emergency_i) begin
                    state_d       = ST_GREEN;
                    phase_d       = next_phase;
                    g_len_d       = green_len;
                    remaining_d   = green_len - 1'b1;
                    phase_start_d = 1'b1;
                end else if (step && !expired) begin
                    remaining_d = remaining_q - 1'b1;
                end
            end
            default: begin
                state_d     = ST_CLEAR;
                remaining_d = R_LOAD;
            end
        endcase

        lights_d = '0;
        for (int p = 0; p < N_PHASES; p++) begin
            if (PW'(p) == phase_d && state_d == ST_GREEN) begin
                lights_d[3*p + GREEN_B] = 1'b1;
            end else if (PW'(p) == phase_d && state_d == ST_YELLOW) begin
                lights_d[3*p + YEL_B] = 1'b1;
            end else begin
                lights_d[3*p + RED_B] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (rst_i) begin
            state_q       <= ST_CLEAR;
            phase_q       <= PW'(N_PHASES - 1);
            remaining_q   <= R_LOAD;
            g_len_q       <= '0;
            phase_start_q <= 1'b0;
            for (int p = 0; p < N_PHASES; p++) begin
                lights_q[3*p +: 3] <= 3'b001;
            end
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            remaining_q   <= remaining_d;
            g_len_q       <= g_len_d;
            phase_start_q <= phase_start_d;
            lights_q      <= lights_d;
        end
    end

    assign lights_o      = lights_q;
    assign phase_o       = phase_q;
    assign state_o       = state_q;
    assign remaining_o   = remaining_q;
    assign g_len_o       = g_len_q;
    assign phase_start_o = phase_start_q;

endmodule

// File: tb/tb_adaptive_phase_ctrl.sv
// Directed, scoreboard-driven bench for adaptive_phase_ctrl with default
// parameters, plus a SKIP_EMPTY=0 instance checked for strict round-robin order.
module tb_adaptive_phase_ctrl;

    localparam logic [1:0] CLR = 2'd0;
    localparam logic [1:0] GRN = 2'd1;
    localparam logic [1:0] YEL = 2'd2;

    typedef struct {
        string      tag;
        logic [1:0] st;
        logic [1:0] ph;
        logic [5:0] rem;
        logic [5:0] gl;
        logic       ps;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, tick, emergency, hold;
    logic [11:0] count;

    logic [8:0] lights;
    logic [1:0] phase, state;
    logic [5:0] remaining, g_len;
    logic       phase_start;

    logic [8:0] ns_lights;
    logic [1:0] ns_phase, ns_state;
    logic [5:0] ns_remaining, ns_g_len;
    logic       ns_phase_start;

    exp_t sb[$];
    int   ns_served[$];
    bit   capture_en = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   r, gcycles;
    bit   done;

    adaptive_phase_ctrl dut (
        .clk_i(clk), .rst_i(rst), .tick_i(tick), .count_i(count),
        .emergency_i(emergency), .hold_i(hold),
        .lights_o(lights), .phase_o(phase), .state_o(state),
        .remaining_o(remaining), .g_len_o(g_len), .phase_start_o(phase_start)
    );

    adaptive_phase_ctrl #(.SKIP_EMPTY(0)) dut_ns (
        .clk_i(clk), .rst_i(rst), .tick_i(tick), .count_i(count),
        .emergency_i(emergency), .hold_i(hold),
        .lights_o(ns_lights), .phase_o(ns_phase), .state_o(ns_state),
        .remaining_o(ns_remaining), .g_len_o(ns_g_len), .phase_start_o(ns_phase_start)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (capture_en && ns_phase_start) ns_served.push_back(int'(ns_phase));
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [8:0] exp_lights(input logic [1:0] st, input logic [1:0] ph);
        logic [8:0] l;
        for (int p = 0; p < 3; p++) begin
            if (p == int'(ph) && st == GRN)      l[3*p +: 3] = 3'b100;
            else if (p == int'(ph) && st == YEL) l[3*p +: 3] = 3'b010;
            else                                 l[3*p +: 3] = 3'b001;
        end
        return l;
    endfunction

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic compare_next();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({e.tag, ".state"},       32'(state),       32'(e.st));
        check({e.tag, ".phase"},       32'(phase),       32'(e.ph));
        check({e.tag, ".remaining"},   32'(remaining),   32'(e.rem));
        check({e.tag, ".g_len"},       32'(g_len),       32'(e.gl));
        check({e.tag, ".phase_start"}, 32'(phase_start), 32'(e.ps));
        check({e.tag, ".lights"},      32'(lights),      32'(exp_lights(e.st, e.ph)));
    endtask

    // n cycles in one state; remaining counts down from rem0 unless frozen.
    task automatic run(input string tag, input logic [1:0] st, input logic [1:0] ph,
                       input int rem0, input int n, input int gl, input bit ps_first,
                       input bit dec);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.tag = tag;
            e.st  = st;
            e.ph  = ph;
            e.rem = 6'(dec ? rem0 - i : rem0);
            e.gl  = 6'(gl);
            e.ps  = ps_first && (i == 0);
            sb.push_back(e);
            step();
            compare_next();
        end
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0; emergency = 1'b0; hold = 1'b0; count = '0;
        step();
        run("reset", CLR, 2'd2, 1, 1, 0, 1'b0, 1'b0);

        // All counts zero, tick tied high: plain round-robin with base greens.
        rst = 1'b0; tick = 1'b1; capture_en = 1'b1;
        run("clr_first", CLR, 2'd2, 0, 1, 0, 1'b0, 1'b1);
        run("g0_base",   GRN, 2'd0, 9, 10, 10, 1'b1, 1'b1);
        run("y0_base",   YEL, 2'd0, 3, 4, 10, 1'b0, 1'b1);
        run("c0_base",   CLR, 2'd0, 1, 2, 10, 1'b0, 1'b1);
        run("g1_base",   GRN, 2'd1, 9, 10, 10, 1'b1, 1'b1);

        // Phase 0 count 3 gives 10 + 6 = 16.
        count = {4'd0, 4'd0, 4'd3};
        run("y1_base",   YEL, 2'd1, 3, 4, 10, 1'b0, 1'b1);
        run("c1_base",   CLR, 2'd1, 1, 2, 10, 1'b0, 1'b1);
        run("g0_cnt3",   GRN, 2'd0, 15, 16, 16, 1'b1, 1'b1);

        // Phase 0 count 15 saturates the extension at 20, green 30.
        count = {4'd0, 4'd0, 4'd15};
        run("y0_cnt3",   YEL, 2'd0, 3, 4, 16, 1'b0, 1'b1);
        run("c0_cnt3",   CLR, 2'd0, 1, 2, 16, 1'b0, 1'b1);
        run("g0_sat_a",  GRN, 2'd0, 29, 5, 30, 1'b1, 1'b1);
        count = {4'd0, 4'd5, 4'd0};
        run("g0_sat_b",  GRN, 2'd0, 24, 25, 30, 1'b0, 1'b1);
        run("y0_sat",    YEL, 2'd0, 3, 4, 30, 1'b0, 1'b1);
        run("c0_sat",    CLR, 2'd0, 1, 2, 30, 1'b0, 1'b1);

        // Only phase 1 occupied: served back to back.
        run("g1_skip_a", GRN, 2'd1, 19, 20, 20, 1'b1, 1'b1);
        run("y1_skip_a", YEL, 2'd1, 3, 4, 20, 1'b0, 1'b1);
        run("c1_skip_a", CLR, 2'd1, 1, 2, 20, 1'b0, 1'b1);
        run("g1_skip_b", GRN, 2'd1, 19, 13, 20, 1'b1, 1'b1);

        // Emergency at remaining 7, together with a tick, held 20 cycles.
        emergency = 1'b1;
        count = {4'd1, 4'd5, 4'd0};
        run("emg_yel",   YEL, 2'd1, 3, 4, 20, 1'b0, 1'b1);
        run("emg_clr",   CLR, 2'd1, 1, 2, 20, 1'b0, 1'b1);
        run("emg_park",  CLR, 2'd1, 0, 14, 20, 1'b0, 1'b0);
        emergency = 1'b0;
        run("emg_rel",   GRN, 2'd2, 11, 1, 12, 1'b1, 1'b1);

        // Tick every 4th cycle, hold over cycles 8..15 swallows two ticks.
        r = 11; gcycles = 1; done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            exp_t e;
            tick = (c % 4 == 3);
            hold = (c >= 8 && c < 16);
            e.tag = "hold_g2"; e.st = GRN; e.ph = 2'd2; e.gl = 6'd12; e.ps = 1'b0;
            if (tick && !hold) begin
                if (r == 0) begin
                    e.st = YEL; r = 3; done = 1'b1;
                end else begin
                    r = r - 1;
                end
            end
            e.rem = 6'(r);
            sb.push_back(e);
            step();
            if (state == GRN) gcycles++;
            compare_next();
        end
        check("hold_reached_yellow", 32'(done), 32'd1);
        check("hold_green_cycles", 32'(gcycles), 32'd56);

        tick = 1'b1; hold = 1'b0;
        run("y2_hold",   YEL, 2'd2, 2, 3, 12, 1'b0, 1'b1);
        run("c2_hold",   CLR, 2'd2, 1, 2, 12, 1'b0, 1'b1);
        run("g1_pre_rst", GRN, 2'd1, 19, 20, 20, 1'b1, 1'b1);
        run("y1_pre_rst", YEL, 2'd1, 3, 2, 20, 1'b0, 1'b1);

        // SKIP_EMPTY=0 instance: strictly round-robin from phase 0.
        capture_en = 1'b0;
        check("ns_served_count", 32'(ns_served.size() >= 5), 32'd1);
        if (ns_served.size() > 0) check("ns_first_phase", 32'(ns_served[0]), 32'd0);
        for (int i = 1; i < ns_served.size(); i++) begin
            check("ns_order", 32'(ns_served[i]), 32'((ns_served[i-1] + 1) % 3));
        end

        // Reset mid-yellow: straight to reset values, no yellow completion.
        rst = 1'b1;
        run("rst_mid_yel", CLR, 2'd2, 1, 1, 0, 1'b0, 1'b0);
        rst = 1'b0;
        run("clr_after_rst", CLR, 2'd2, 0, 1, 0, 1'b0, 1'b1);
        run("g1_after_rst",  GRN, 2'd1, 19, 1, 20, 1'b1, 1'b1);

        // Hold freezes green; emergency still pre-empts through hold.
        hold = 1'b1;
        run("hold_freeze",   GRN, 2'd1, 19, 3, 20, 1'b0, 1'b0);
        emergency = 1'b1;
        run("emg_over_hold", YEL, 2'd1, 3, 1, 20, 1'b0, 1'b1);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adaptive_phase_ctrl.md
# adaptive_phase_ctrl

Parametrised, count-adaptive traffic-phase controller for an intersection with N_PHASES signal groups. It serves phases round-robin, sizes each green from that phase's car count, skips empty phases, and supports hold and emergency pre-emption. It sits between the per-approach `car_count` instances and the status/LCD path. It exports state, phase, remaining time and green length for the message generator.

## Interface
- `N_PHASES`, 3, number of signal groups (≥2)
- `CNT_W`, 4, width of each per-phase car count
- `TW`, 6, timer width in ticks
- `G_MIN`, 10, base green ticks (≥1)
- `G_MAX`, 30, maximum green ticks (G_MIN ≤ G_MAX < 2^TW)
- `EXT_PER_CAR`, 2, extra green ticks per counted car
- `Y_TICKS`, 4, yellow ticks (≥1)
- `R_TICKS`, 2, all-red clearance ticks (≥1)
- `SKIP_EMPTY`, 1, 1 = skip phases with zero count

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `tick` in 1: timing enable, one-cycle pulse (e.g. 2 Hz strobe)
- `count` in N_PHASES*CNT_W: phase p count at [p*CNT_W +: CNT_W]
- `emergency` in 1: pre-emption request, level
- `hold` in 1: freeze timer, level
- `lights` out 3*N_PHASES: phase p at [3p+2:3p] = {green, yellow, red}
- `phase` out $clog2(N_PHASES): phase being served or last served
- `state` out 2: current state encoding
- `remaining` out TW: ticks left in current state minus one
- `g_len` out TW: green length latched for the current or last green
- `phase_start` out 1: one-cycle pulse on entry to GREEN

## Operation
- States: CLEAR=0, GREEN=1, YELLOW=2.
- Lights are a registered decode of state and phase:
  - GREEN: phase p = 100, all others = 001.
  - YELLOW: phase p = 010, all others = 001.
  - CLEAR: all phases = 001.
- Timer: on entry to a state of D ticks, `remaining` loads D-1. On a cycle with `tick`=1 and `hold`=0:
  - `remaining`==0 causes the state transition.
  - Otherwise `remaining` decrements.
- CLEAR → GREEN, when the CLEAR timer expires and `emergency`=0:
  - Search candidates (phase+1) mod N, (phase+2) mod N, … through phase itself.
  - Select the first candidate with nonzero count. If SKIP_EMPTY=0 or all counts are zero, select (phase+1) mod N.
- Green length is computed from the selected phase's count, sampled in the transition cycle:
  - ext = min(count × EXT_PER_CAR, G_MAX − G_MIN), computed at full width without overflow.
  - g_len = G_MIN + ext; `remaining` loads g_len−1.
  - `phase_start`=1 in the first GREEN cycle only.
- GREEN → YELLOW on timer expiry; `remaining` loads Y_TICKS−1.
- YELLOW → CLEAR on timer expiry; `remaining` loads R_TICKS−1.
- Emergency:
  - In GREEN, `emergency`=1 forces YELLOW on the next cycle, regardless of `tick`/`hold`.
  - In YELLOW, emergency has no effect; the yellow completes normally.
  - In CLEAR with expired timer, the block stays in CLEAR with `remaining`=0 while `emergency`=1.
  - On release, GREEN selection happens on the next tick.
  - Emergency has priority over `hold`.
- `hold`=1 freezes `remaining` and state, except for emergency pre-emption in GREEN.
- Counts are sampled only at CLEAR→GREEN; changes during GREEN do not alter its length.

## Timing
- Reset values: state=CLEAR, phase=N_PHASES−1, `remaining`=R_TICKS−1, lights all 001, `g_len`=0, `phase_start`=0.
- First green after reset is the search starting at phase 0.
- `rst` mid-operation returns all outputs to the reset values on the next edge, with no yellow.
- With `tick` tied high, each state lasts exactly D cycles: GREEN = g_len, YELLOW = Y_TICKS, CLEAR = R_TICKS.
- All outputs are registered. Lights and `state` change in the same cycle, one cycle after the deciding edge inputs.
- `tick` and `emergency` in the same cycle during GREEN: emergency wins, and the timer loads Y_TICKS−1.

## Structure
- Shared package holds:
  - State encodings CLEAR/GREEN/YELLOW.
  - Light bit positions: GREEN_B=2, YEL_B=1, RED_B=0.
- Sub-module `phase_select`: combinational rotate-priority search (inputs: count bus, current phase, SKIP_EMPTY; outputs: next phase, selected count).
- Green-length arithmetic and the FSM stay in the top of the block.

## Test plan
- Reset, `tick`=1, all counts 0, default params: 2 cycles CLEAR, phase 0 green 10, yellow 4, clear 2, then phase 1 green 10; `phase_start` pulses once per green.
- Phase-0 count=3 → g_len=16. Phase-0 count=15 → ext saturates at 20, so g_len=30 and green lasts 30 cycles.
- Counts {0,5,0}, SKIP_EMPTY=1 → phase 1 served repeatedly. Same counts with SKIP_EMPTY=0 → order 0,1,2.
- `emergency` asserted in GREEN at `remaining`=7 → next cycle YELLOW with `remaining`=3. Held 20 cycles → CLEAR with all red throughout. On release → next green after one tick, at (phase+1) search.
- `tick` every 4th cycle with `hold` pulsed 8 cycles during GREEN → `remaining` steps only on unheld ticks; total green = g_len ticks plus the held interval.
- `rst` asserted mid-YELLOW → next cycle state=CLEAR, lights all 001, phase=N−1, `remaining`=1, `g_len`=0.
